button_event_sequencer: RTL and testbench
=========================================

Name: button_event_sequencer

Overview:
- Sits downstream of the debouncer/edge-detector pair; consumes `debounced` (level) and `edge_trig` (one-cycle rising-edge pulse).
- Classifies each press into one of three gesture events and presents them on a valid/ready event port: SHORT press, LONG press (held past a threshold), or DOUBLE click (second press inside a gap window).
- Timing is derived from an internal restartable prescaler, so thresholds are in ticks, not raw clocks.

Parameters:
- TICK_DIV, 100000: clock cycles per timing tick (1 ms at 100 MHz); must be ≥2.
- LONG_TICKS, 500: ticks a first press must be held to produce LONG.
- GAP_TICKS, 250: ticks after a short release within which a second press produces DOUBLE.
- CNT_W, 10: tick counter width; must satisfy 2^CNT_W > max(LONG_TICKS, GAP_TICKS).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- debounced  input  1  debounced button level, 1 = pressed
- edge_trig  input  1  one-cycle pulse on debounced rising edge
- evt_valid  output  1  event available
- evt_code  output  2  01 SHORT, 10 LONG, 11 DOUBLE, 00 never presented while valid
- evt_ready  input  1  consumer accepts event when evt_valid && evt_ready
- evt_ovf  output  1  sticky: an event was dropped because the output was occupied
- busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (reset=0, async): FSM→IDLE, tick counter=0, prescaler=0, evt_valid=0, evt_code=00, evt_ovf=0, busy=0. Deassertion is synchronous to clk.
- States: IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD.
- Counting and prescaler rules:
  - Prescaler and tick counter clear on every transition into PRESS1 or WAIT2.
  - The tick counter increments once per TICK_DIV cycles in those states and saturates at all-ones.
- IDLE:
  - edge_trig=1 → PRESS1.
  - In all other states edge_trig is ignored except where listed.
- PRESS1:
  - debounced=0 before LONG_TICKS is reached → WAIT2.
  - Tick counter reaching LONG_TICKS while debounced=1 → emit LONG, → LONG_HELD.
  - LONG is emitted exactly LONG_TICKS*TICK_DIV cycles after the cycle edge_trig was sampled high; evt_valid rises on the following clock edge.
  - If release and threshold occur in the same cycle, the release wins (→ WAIT2, no LONG).
- LONG_HELD: debounced=0 → IDLE. No further events for this press.
- WAIT2:
  - edge_trig=1 → emit DOUBLE, → PRESS2.
  - Tick counter reaching GAP_TICKS with no edge → emit SHORT, → IDLE.
  - Edge and timeout in the same cycle: edge wins (DOUBLE).
- PRESS2:
  - debounced=0 → IDLE.
  - No LONG detection on the second press.
- Output register:
  - "Emit" loads evt_code and sets evt_valid on the next edge.
  - evt_valid/evt_code hold stable until a handshake (evt_valid && evt_ready).
  - A handshake with no new emit clears evt_valid; evt_code is unchanged.
  - Emit on the same cycle as a handshake: the new event loads and evt_valid stays 1.
  - Emit while evt_valid=1 and evt_ready=0: the new event is dropped, the old one is retained, and evt_ovf is set.
  - evt_ovf clears only on reset.
- Reset mid-gesture: the gesture is abandoned, no event is emitted, and any pending event is discarded.
- busy is a registered decode of the state.

Decomposition:
- Shared package btn_evt_pkg:
  - state encoding enum (IDLE, PRESS1, WAIT2, PRESS2, LONG_HELD);
  - event code constants EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_DOUBLE=2'b11.
- One sub-module, tick_prescaler:
  - ports: clk, reset (active-low async), clr, tick;
  - counts 0..TICK_DIV-1 and pulses tick for one cycle at wrap;
  - clr forces the count to 0 with no tick.

Test Plan (TICK_DIV=4, LONG_TICKS=5, GAP_TICKS=3, evt_ready=1 unless stated):
- SHORT: edge_trig at cycle 0, release at cycle 8 → evt_valid one cycle with code 01 once 12 cycles have elapsed in WAIT2; busy returns 0.
- LONG: edge_trig at cycle 0, hold 40 cycles → code 10 emitted once at the 20-cycle threshold; no event on release; busy drops after release.
- DOUBLE: press 6 cycles, release, second edge_trig 5 cycles later → code 11 emitted immediately; no SHORT is ever emitted; release → IDLE.
- Backpressure: evt_ready=0, produce SHORT then LONG → evt_code stays 01, evt_ovf=1; raise evt_ready → single handshake, evt_valid=0.
- Boundary: release in the exact cycle the LONG threshold hits → no LONG, then SHORT after the gap; second edge in the exact timeout cycle → DOUBLE.
- Reset mid-operation: assert reset low during PRESS1 with evt_valid=1 → all outputs 0 asynchronously; after deassertion, a fresh edge_trig behaves normally.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event sequencer.
//   btn_state_e : gesture classifier state encoding
//   EVT_*       : event codes presented on evt_code
//   evt_t       : internal emit request (valid + code)
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } btn_state_e;

  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } evt_t;

endpackage

// File: rtl/tick_prescaler.sv
// Restartable prescaler: counts 0..TICK_DIV-1 and asserts tick while the
// count sits at TICK_DIV-1, i.e. one cycle per wrap.
//   clk   : system clock
//   reset : async active-low reset
//   clr   : restart the count at 0 (no tick on the following cycle)
//   tick  : one-cycle timing pulse
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt_next;
  logic          r_tick;

  // Wrapping increment
  always_comb begin
    w_cnt_next = r_cnt + PW'(1);
    if (r_cnt == LAST) w_cnt_next = '0;
  end

  // tick is registered from the next count so it lines up with count == LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tick <= (w_cnt_next == LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/button_event_sequencer.sv
// Classifies debounced button presses into SHORT / LONG / DOUBLE events and
// presents them on a valid/ready port. Timing thresholds are in prescaler ticks.
//   clk, reset (async active-low)
//   debounced : button level, 1 = pressed
//   edge_trig : one-cycle pulse on the debounced rising edge
//   evt_valid/evt_code/evt_ready : event handshake (01 SHORT, 10 LONG, 11 DOUBLE)
//   evt_ovf   : sticky, an event was dropped while the output was occupied
//   busy      : classifier is mid-gesture
module button_event_sequencer
  import btn_evt_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned LONG_TICKS = 500,
  parameter int unsigned GAP_TICKS  = 250,
  parameter int unsigned CNT_W      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       debounced,
  input  logic       edge_trig,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  btn_state_e       r_state;
  btn_state_e       w_state_next;
  logic             w_clr;
  logic             w_tick;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [CNT_W-1:0] w_tick_cnt_inc;
  evt_t             w_emit;
  logic             r_evt_valid;
  logic [1:0]       r_evt_code;
  logic             r_evt_ovf;
  logic             r_busy;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Tick count as it will be after this edge; thresholds compare against this
  // so an event fires on the edge where the count reaches its limit.
  always_comb begin
    w_tick_cnt_inc = r_tick_cnt;
    if (w_tick && (r_state == PRESS1 || r_state == WAIT2) && (r_tick_cnt != CNT_MAX)) begin
      w_tick_cnt_inc = r_tick_cnt + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, timer restart and emit decisions
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_emit       = '0;
    case (r_state)
      IDLE: begin
        if (edge_trig) begin
          w_state_next = PRESS1;
          w_clr        = 1'b1;
        end
      end
      PRESS1: begin
        // release takes priority over a coincident LONG threshold
        if (!debounced) begin
          w_state_next = WAIT2;
          w_clr        = 1'b1;
        end else if (w_tick_cnt_inc == LONG_CNT) begin
          w_state_next = LONG_HELD;
          w_emit       = '{valid: 1'b1, code: EVT_LONG};
        end
      end
      WAIT2: begin
        // second edge takes priority over a coincident gap timeout
        if (edge_trig) begin
          w_state_next = PRESS2;
          w_emit       = '{valid: 1'b1, code: EVT_DOUBLE};
        end else if (w_tick_cnt_inc == GAP_CNT) begin
          w_state_next = IDLE;
          w_emit       = '{valid: 1'b1, code: EVT_SHORT};
        end
      end
      PRESS2, LONG_HELD: begin
        if (!debounced) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Tick counter, restarted on entry to a timed state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_tick_cnt <= '0;
    else if (w_clr) r_tick_cnt <= '0;
    else            r_tick_cnt <= w_tick_cnt_inc;
  end

  // Output event register with drop-on-full overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= 2'b00;
      r_evt_ovf   <= 1'b0;
    end else if (w_emit.valid) begin
      if (!r_evt_valid || evt_ready) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_emit.code;
      end else begin
        r_evt_ovf <= 1'b1;
      end
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  // busy tracks the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= 1'b0;
    else        r_busy <= (w_state_next != IDLE);
  end

  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_ovf   = r_evt_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_button_event_sequencer.sv
// Self-checking bench for button_event_sequencer (TICK_DIV=4, LONG=5, GAP=3).
// A cycle-age reference model is compared against the DUT every cycle; directed
// gestures additionally check hand-computed event latencies and codes.
module tb_button_event_sequencer;

  localparam int DIV      = 4;
  localparam int LONG_T   = 5;
  localparam int GAP_T    = 3;
  localparam int LONG_CYC = LONG_T * DIV;
  localparam int GAP_CYC  = GAP_T * DIV;

  localparam int P_IDLE   = 0;
  localparam int P_FIRST  = 1;
  localparam int P_GAP    = 2;
  localparam int P_SECOND = 3;
  localparam int P_HELD   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       debounced = 1'b0;
  logic       edge_trig = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ovf;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  button_event_sequencer #(
    .TICK_DIV   (DIV),
    .LONG_TICKS (LONG_T),
    .GAP_TICKS  (GAP_T),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .debounced (debounced),
    .edge_trig (edge_trig),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_ovf   (evt_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle counter and event-rise monitor
  int         cyc = 0;
  int         n_rise = 0;
  int         last_rise = -1;
  logic [1:0] rise_code = 2'b00;
  logic       mon_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (evt_valid === 1'b1 && mon_prev !== 1'b1) begin
      n_rise    <= n_rise + 1;
      last_rise <= cyc;
      rise_code <= evt_code;
    end
    mon_prev <= evt_valid;
  end

  // Reference model: phase plus cycles elapsed since entering it
  int         m_phase;
  int         m_age;
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_ovf;

  always @(posedge clk or negedge reset) begin : p_model
    int         ph;
    int         age;
    logic [1:0] ev;
    if (!reset) begin
      m_phase <= P_IDLE;
      m_age   <= 0;
      m_valid <= 1'b0;
      m_code  <= 2'b00;
      m_ovf   <= 1'b0;
    end else begin
      ph  = m_phase;
      age = m_age + 1;
      ev  = 2'b00;
      case (m_phase)
        P_IDLE:  if (edge_trig) begin ph = P_FIRST; age = 0; end
        P_FIRST: begin
          if (!debounced) begin ph = P_GAP; age = 0; end
          else if (age == LONG_CYC) begin ev = 2'b10; ph = P_HELD; end
        end
        P_GAP: begin
          if (edge_trig) begin ev = 2'b11; ph = P_SECOND; end
          else if (age == GAP_CYC) begin ev = 2'b01; ph = P_IDLE; end
        end
        default: if (!debounced) ph = P_IDLE;
      endcase
      m_phase <= ph;
      m_age   <= age;
      if (ev != 2'b00) begin
        if (!m_valid || evt_ready) begin
          m_valid <= 1'b1;
          m_code  <= ev;
        end else begin
          m_ovf <= 1'b1;
        end
      end else if (m_valid && evt_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("cmp_evt_valid", 32'(evt_valid), 32'(m_valid));
    check("cmp_evt_code",  32'(evt_code),  32'(m_code));
    check("cmp_evt_ovf",   32'(evt_ovf),   32'(m_ovf));
    check("cmp_busy",      32'(busy),      32'(m_phase != P_IDLE));
  end

  task automatic step(input logic d, input logic e);
    @(negedge clk);
    debounced = d;
    edge_trig = e;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  initial begin : p_watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : p_stim
    int   t0;
    int   r0;
    logic lvl;
    logic nl;
    int   rem;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code",  32'(evt_code),  32'd0);
    check("rst_ovf",   32'(evt_ovf),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    reset = 1'b1;

    // SHORT: press at 0, release at 8, event after a 12-cycle gap
    evt_ready = 1'b1;
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 7);
    step(0, 0);
    hold(0, 16);
    check("short_count", 32'(n_rise - r0), 32'd1);
    check("short_dly",   32'(last_rise - t0), 32'd20);
    check("short_code",  32'(rise_code), 32'd1);
    check("short_busy",  32'(busy), 32'd0);
    check("short_valid_gone", 32'(evt_valid), 32'd0);

    // LONG: 40-cycle hold, event at the 20-cycle threshold only
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 39);
    hold(0, 3);
    check("long_count", 32'(n_rise - r0), 32'd1);
    check("long_dly",   32'(last_rise - t0), 32'd20);
    check("long_code",  32'(rise_code), 32'd2);
    check("long_busy",  32'(busy), 32'd0);

    // DOUBLE: second edge 5 cycles after release, no SHORT afterwards
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 5);
    step(0, 0);
    hold(0, 4);
    step(1, 1);
    hold(1, 3);
    hold(0, 20);
    check("double_count", 32'(n_rise - r0), 32'd1);
    check("double_dly",   32'(last_rise - t0), 32'd11);
    check("double_code",  32'(rise_code), 32'd3);
    check("double_busy",  32'(busy), 32'd0);

    // Backpressure: SHORT held, LONG dropped, then one handshake
    evt_ready = 1'b0;
    r0 = n_rise;
    step(1, 1);
    hold(1, 1);
    step(0, 0);
    hold(0, 14);
    step(1, 1);
    hold(1, 25);
    hold(0, 2);
    check("bp_count", 32'(n_rise - r0), 32'd1);
    check("bp_valid", 32'(evt_valid), 32'd1);
    check("bp_code",  32'(evt_code), 32'd1);
    check("bp_ovf",   32'(evt_ovf), 32'd1);
    evt_ready = 1'b1;
    hold(0, 1);
    check("bp_hs_valid", 32'(evt_valid), 32'd0);
    check("bp_hs_code",  32'(evt_code), 32'd1);
    check("bp_hs_ovf",   32'(evt_ovf), 32'd1);

    // Boundary: release exactly on the LONG threshold -> SHORT after the gap
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 19);
    step(0, 0);
    hold(0, 15);
    check("bnd_rel_count", 32'(n_rise - r0), 32'd1);
    check("bnd_rel_dly",   32'(last_rise - t0), 32'd32);
    check("bnd_rel_code",  32'(rise_code), 32'd1);

    // Boundary: second edge exactly on the gap timeout -> DOUBLE
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 1);
    step(0, 0);
    hold(0, 11);
    step(1, 1);
    hold(1, 2);
    hold(0, 16);
    check("bnd_gap_count", 32'(n_rise - r0), 32'd1);
    check("bnd_gap_dly",   32'(last_rise - t0), 32'd14);
    check("bnd_gap_code",  32'(rise_code), 32'd3);

    // Reset mid-press with an event pending
    evt_ready = 1'b0;
    step(1, 1);
    hold(1, 1);
    step(0, 0);
    hold(0, 14);
    step(1, 1);
    hold(1, 3);
    check("pre_rst_busy",  32'(busy), 32'd1);
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_code",  32'(evt_code),  32'd0);
    check("async_rst_ovf",   32'(evt_ovf),   32'd0);
    check("async_rst_busy",  32'(busy),      32'd0);
    @(negedge clk);
    debounced = 1'b0;
    edge_trig = 1'b0;
    reset     = 1'b1;
    evt_ready = 1'b1;
    r0 = n_rise;
    step(1, 1); t0 = cyc;
    hold(1, 2);
    step(0, 0);
    hold(0, 15);
    check("post_rst_count", 32'(n_rise - r0), 32'd1);
    check("post_rst_dly",   32'(last_rise - t0), 32'd15);
    check("post_rst_code",  32'(rise_code), 32'd1);

    // Randomised gestures with random backpressure, checked by the model
    lvl = 1'b0;
    rem = 5;
    for (int i = 0; i < 3000; i++) begin
      nl = lvl;
      if (rem == 0) begin
        nl  = ~lvl;
        rem = nl ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 18));
      end else begin
        rem = rem - 1;
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      step(nl, nl && !lvl);
      lvl = nl;
    end
    evt_ready = 1'b1;
    hold(0, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
